// File: rtl/uart_pkg.sv
// Shared types and the parity helper for the UART transmitter.
package uart_pkg;

  localparam int MAX_DATA_BITS = 9;
  localparam int BIT_CNT_W     = 4;
  localparam int BREAK_BITS    = 10;

  typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN, PAR_MARK} parity_e;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} tx_state_e;

  // Unused upper bits must be zero so they do not disturb the XOR reduction.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                       input parity_e                  mode);
    case (mode)
      PAR_ODD:  return ~^data;
      PAR_EVEN: return ^data;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags and sync active-low reset.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             push, pop;

  always_comb begin
    push     = wr_en && !full_q;
    pop      = rd_en && !empty_q;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with baud divider, input FIFO and runtime parity/stop config.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  input  logic [DATA_BITS-1:0] s_data,
  output logic                 s_ready,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  output logic                 rs422_tx,
  output logic                 busy,
  output logic                 tx_done
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                 break_req
`endif
);

  localparam int CNT_W = $clog2(CLK_DIV);

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 par_en_q, par_en_d;
  logic                 stop2_q, stop2_d;
  logic                 tx_q, tx_d;
  logic                 tx_done_q, tx_done_d;
  logic                 busy_q, busy_d;
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 load, tick, par_calc;
`ifdef UART_TX_BREAK_EN
  logic                 brk_mark_q, brk_mark_d;
`endif

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (s_valid),
    .wr_data (s_data),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign tick     = (baud_q == CNT_W'(CLK_DIV - 1));
  assign par_calc = calc_parity(MAX_DATA_BITS'(fifo_rdata), parity_e'(cfg_parity));

  always_comb begin
    state_d   = state_q;
    baud_d    = '0;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
    stop2_d   = stop2_q;
    tx_done_d = 1'b0;
    load      = 1'b0;
    fifo_pop  = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_mark_d = brk_mark_q;
`endif

    if (state_q != IDLE) begin
      baud_d = tick ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (break_req) begin
          state_d    = BREAK;
          bit_cnt_d  = '0;
          brk_mark_d = 1'b0;
        end else
`endif
        if (!fifo_empty) begin
          load = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
            state_d   = par_en_q ? PARITY : STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d   = STOP;
          bit_cnt_d = '0;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop2_q && bit_cnt_q == '0) begin
            bit_cnt_d = BIT_CNT_W'(1);
          end else begin
            tx_done_d = 1'b1;
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      // Bit ticks are counted until a full frame time has passed; the
      // trailing mark bit reuses the same state.
      BREAK: begin
        if (tick) begin
          if (brk_mark_q) begin
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else if (bit_cnt_q >= BIT_CNT_W'(BREAK_BITS - 1)) begin
            if (!break_req) begin
              brk_mark_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Configuration is captured with the word so mid-frame changes are ignored.
    if (load) begin
      fifo_pop  = 1'b1;
      shift_d   = fifo_rdata;
      par_bit_d = par_calc;
      par_en_d  = (cfg_parity != 2'b00);
      stop2_d   = cfg_stop2;
      bit_cnt_d = '0;
      state_d   = START;
    end

    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      PARITY:  tx_d = par_bit_q;
`ifdef UART_TX_BREAK_EN
      BREAK:   tx_d = brk_mark_q;
`endif
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_q != IDLE) || !fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_mark_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
      busy_q     <= busy_d;
`ifdef UART_TX_BREAK_EN
      brk_mark_q <= brk_mark_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    shift_q   <= shift_d;
    par_bit_q <= par_bit_d;
    par_en_q  <= par_en_d;
    stop2_q   <= stop2_d;
  end

  assign s_ready  = !fifo_full;
  assign rs422_tx = tx_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Scoreboard bench for uart_tx_fifo_param: a line-level receiver model decodes
// every frame and compares it with the word/config queued at push time.
module tb_uart_tx_fifo_param;

  localparam int CLK_DIV    = 4;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready;
  logic [1:0] cfg_parity = 2'b00;
  logic       cfg_stop2 = 1'b0;
  logic       rs422_tx, busy, tx_done;
`ifdef UART_TX_BREAK_EN
  logic       break_req = 1'b0;
`endif

  uart_tx_fifo_param #(
    .CLK_DIV    (CLK_DIV),
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .rs422_tx   (rs422_tx),
    .busy       (busy),
    .tx_done    (tx_done)
`ifdef UART_TX_BREAK_EN
    ,
    .break_req  (break_req)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic [1:0] par;
    logic       stop2;
  } exp_t;

  exp_t        sb[$];
  int unsigned done_q[$];
  int          checks = 0;
  int          failures = 0;
  int          frames = 0;
  logic        mon_en = 1'b1;
  logic        in_frame = 1'b0;
  int unsigned last_start = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Line image of a frame: start, data LSB first, optional parity, stops, idle ones.
  function automatic logic [15:0] expected_bits(input exp_t e, output int n);
    logic [15:0] b;
    logic        ones_odd;
    int          k;
    b        = '1;
    b[0]     = 1'b0;
    ones_odd = 1'($countones(e.data) % 2);
    for (int i = 0; i < 8; i++) b[1+i] = e.data[i];
    k = 9;
    if (e.par != 2'b00) begin
      case (e.par)
        2'b01:   b[k] = ~ones_odd;
        2'b10:   b[k] = ones_odd;
        default: b[k] = 1'b1;
      endcase
      k++;
    end
    n = k + (e.stop2 ? 2 : 1);
    return b;
  endfunction

  initial begin : monitor
    exp_t        e;
    logic [15:0] exp_b, got_b;
    int          n;
    bit          width_ok, done_end, done_early, abort;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && rs422_tx === 1'b0) begin
        in_frame   = 1'b1;
        last_start = cyc;
        if (sb.size() == 0) begin
          fail_now("unexpected_frame");
          e = '{data: 8'h00, par: 2'b00, stop2: 1'b0};
        end else begin
          e = sb.pop_front();
        end
        exp_b      = expected_bits(e, n);
        got_b      = '1;
        width_ok   = 1'b1;
        done_end   = 1'b0;
        done_early = 1'b0;
        abort      = 1'b0;
        for (int s = 0; s < n && !abort; s++) begin
          for (int c = 0; c < CLK_DIV && !abort; c++) begin
            if (s != 0 || c != 0) @(negedge clk);
            if (!rst_n) begin
              abort = 1'b1;
            end else begin
              if (c == 0) got_b[s] = rs422_tx;
              else if (rs422_tx !== got_b[s]) width_ok = 1'b0;
              if (tx_done === 1'b1) begin
                if (s == n - 1 && c == CLK_DIV - 1) done_end = 1'b1;
                else done_early = 1'b1;
              end
            end
          end
        end
        if (!abort) begin
          frames++;
          chk("frame_bits", got_b, exp_b);
          chk("bit_width", width_ok, 1);
          chk("done_at_end", {done_early, done_end}, 2'b01);
        end
        in_frame = 1'b0;
      end
    end
  end

  always @(negedge clk) if (tx_done === 1'b1) done_q.push_back(cyc);

  task automatic push_word(input logic [7:0] d, output int unsigned acc_cyc);
    bit acc;
    int t;
    acc     = 1'b0;
    t       = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!acc && t < 2000) begin
      acc = s_ready;
      @(posedge clk);
      t++;
    end
    #1;
    if (!acc) fail_now("push_timeout");
    else sb.push_back('{data: d, par: cfg_parity, stop2: cfg_stop2});
    acc_cyc = cyc;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || in_frame || busy !== 1'b0) && t < 6000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 6000) fail_now("idle_timeout");
    @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned pc, ac[6];
    logic [7:0]  words[6];
    logic        r5;
    int          t;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", rs422_tx, 1);
    chk("rst_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 8N1 0xA5: latency, length, single done pulse, busy drop
    done_q.delete();
    push_word(8'hA5, pc);
    s_valid = 1'b0;
    t = 0;
    while (tx_done !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("t1_done_seen", tx_done, 1);
    chk("t1_latency", longint'(last_start) - longint'(pc), 2);
    if (done_q.size() > 0) chk("t1_frame_len", done_q[0] - last_start + 1, 40);
    @(negedge clk);
    chk("t1_busy_after", busy, 0);
    chk("t1_done_width", tx_done, 0);
    wait_idle();
    chk("t1_done_pulses", done_q.size(), 1);

    // parity odd then even
    cfg_parity = 2'b01;
    push_word(8'hA5, pc);
    s_valid = 1'b0;
    wait_idle();
    cfg_parity = 2'b10;
    done_q.delete();
    push_word(8'hA5, pc);
    s_valid = 1'b0;
    wait_idle();
    if (done_q.size() > 0) chk("t2_frame_len", done_q[0] - last_start + 1, 44);

    // two stop bits, back-to-back
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b1;
    done_q.delete();
    push_word(8'h00, pc);
    push_word(8'hFF, pc);
    s_valid = 1'b0;
    wait_idle();
    chk("t3_pulses", done_q.size(), 2);
    if (done_q.size() == 2) chk("t3_spacing", done_q[1] - done_q[0], 44);

    // FIFO fill: six words on consecutive cycles
    cfg_stop2 = 1'b0;
    r5 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      words[i] = 8'($urandom);
      push_word(words[i], ac[i]);
      if (i == 4) r5 = s_ready;
    end
    s_valid = 1'b0;
    chk("t4_ready_low", r5, 0);
    chk("t4_burst", ac[4] - ac[0], 4);
    chk("t4_sixth_wait", ac[5] > ac[4] + 30, 1);
    wait_idle();

    // reset during data bit 3
    push_word(8'hC3, pc);
    s_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_tx", rs422_tx, 1);
    chk("t5_busy", busy, 0);
    chk("t5_ready", s_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    push_word(8'h3C, pc);
    s_valid = 1'b0;
    wait_idle();

    // config change after the word was taken must not affect its frame
    cfg_parity = 2'b10;
    push_word(8'h5A, pc);
    s_valid = 1'b0;
    repeat (10) @(negedge clk);
    cfg_parity = 2'b01;
    cfg_stop2  = 1'b1;
    wait_idle();

    // randomized words and configurations
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 0) begin
        s_valid = 1'b0;
        wait_idle();
        cfg_parity = 2'($urandom_range(0, 3));
        cfg_stop2  = 1'($urandom_range(0, 1));
      end
      push_word(8'($urandom), pc);
      if ($urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
      end
    end
    s_valid = 1'b0;
    wait_idle();

`ifdef UART_TX_BREAK_EN
    begin
      int   lows, highs;
      logic bb;
      cfg_parity = 2'b00;
      cfg_stop2  = 1'b0;
      mon_en     = 1'b0;
      bb         = 1'b0;
      @(negedge clk);
      break_req = 1'b1;
      s_valid   = 1'b1;
      s_data    = 8'h55;
      sb.push_back('{data: 8'h55, par: 2'b00, stop2: 1'b0});
      @(negedge clk);
      s_valid = 1'b0;
      repeat (4) @(negedge clk);
      break_req = 1'b0;
      t = 0;
      while (rs422_tx !== 1'b0 && t < 10) begin
        @(negedge clk);
        t++;
      end
      lows = 0;
      while (rs422_tx === 1'b0 && lows < 200) begin
        lows++;
        if (lows == 10) bb = busy;
        @(negedge clk);
      end
      mon_en = 1'b1;
      chk("brk_low", lows, 40);
      chk("brk_busy", bb, 1);
      highs = 0;
      while (rs422_tx === 1'b1 && highs < 50) begin
        highs++;
        @(negedge clk);
      end
      chk("brk_mark", highs, 4);
      wait_idle();
    end
`endif

    chk("sb_drained", sb.size(), 0);
    chk("frames_min", frames >= 30, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
